// File: rtl/holy_axil_ram.sv
// AXI-Lite slave RAM serving the BASE_ADDR window with independent write and read FSMs.
// Optional feature macro HOLY_AXIL_RAM_ERR_EN: out-of-range accesses answer SLVERR instead of wrapping.
module holy_axil_ram #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned SIZE_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axi_lite_awaddr,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic [3:0]  s_axi_lite_wstrb,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [31:0] s_axi_lite_araddr,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready
);

    localparam int unsigned WORDS = SIZE_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_RESP} rd_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d;

    rd_state_e        rd_state_q, rd_state_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_oor, rd_oor;
    logic             aw_hs, w_hs;

    // Offsets are taken modulo 2^32, then truncated to the word index.
    assign wr_idx = IDX_W'(((awaddr_q - BASE_ADDR) >> 2) & (WORDS - 1));
    assign rd_idx = IDX_W'(((araddr_q - BASE_ADDR) >> 2) & (WORDS - 1));

`ifdef HOLY_AXIL_RAM_ERR_EN
    assign wr_oor = (awaddr_q - BASE_ADDR) >= SIZE_BYTES;
    assign rd_oor = (araddr_q - BASE_ADDR) >= SIZE_BYTES;
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // All handshake outputs decode registered state only.
    assign s_axi_lite_awready = (wr_state_q == WR_COLLECT) && !aw_held_q;
    assign s_axi_lite_wready  = (wr_state_q == WR_COLLECT) && !w_held_q;
    assign s_axi_lite_bvalid  = (wr_state_q == WR_RESP);
    assign s_axi_lite_bresp   = bresp_q;
    assign s_axi_lite_arready = (rd_state_q == RD_IDLE);
    assign s_axi_lite_rvalid  = (rd_state_q == RD_RESP);
    assign s_axi_lite_rdata   = rdata_q;
    assign s_axi_lite_rresp   = rresp_q;

    assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        unique case (wr_state_q)
            WR_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_lite_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_lite_wdata;
                    wstrb_d  = s_axi_lite_wstrb;
                end
                if (aw_held_d && w_held_d) wr_state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                bresp_d    = wr_oor ? RESP_SLVERR : RESP_OKAY;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_lite_bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_COLLECT;
                end
            end
            default: wr_state_d = WR_COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // NOTE: the memory array has no reset so it maps onto block RAM; only its write enable is reset-gated.
    always_ff @(posedge clk) begin
        if (wr_state_q == WR_COMMIT && !wr_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Reading in RD_READ samples mem before a same-edge commit lands: read-first.
    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (s_axi_lite_arvalid) begin
                    araddr_d   = s_axi_lite_araddr;
                    rd_state_d = RD_READ;
                end
            end
            RD_READ: begin
                rdata_d    = rd_oor ? 32'h0 : mem[rd_idx];
                rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
                rd_state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_lite_rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule
